// File: rtl/hazard_ctrl_pkg.sv
// Purpose : shared constants, types and helpers for the pipeline hazard controller.
// Latency : n/a (package).
// Backpressure: n/a (package).
package hazard_ctrl_pkg;

  // Width of the tuse/tnew fields.
  localparam int TNEW_W = 3;

  // Multiply/divide unit busy lengths. These are also used by the decoder and
  // the bypass muxes, so they live here rather than in the controller.
  localparam int MD_MULT_CYC = 5;
  localparam int MD_DIV_CYC  = 10;

  // Forwarding mux select encodings.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef logic [TNEW_W-1:0] tnew_t;

  // tuse value meaning "this operand is not read".
  localparam tnew_t TUSE_NONE = tnew_t'(5);

  // One shadow pipeline stage. All-zero is the bubble state.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic       we;
    tnew_t      tnew;
  } stage_t;

  // Decrement that floors at zero.
  function automatic tnew_t sat_dec(tnew_t t);
    return (t == '0) ? '0 : t - tnew_t'(1);
  endfunction

  // A stage produces a usable register result only if it writes a non-zero register.
  function automatic logic wr_valid(stage_t s);
    return s.we && (s.wa != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Purpose : D-stage decode info into the hazard controller, stall/forward controls out.
// Latency : n/a (wires only).
// Backpressure: stall_FD/bubble_E are the backpressure to the fetch/decode stages.
// Ports   : rs_D/rt_D/wa_D addresses, tuse_Drs/tuse_Drt/tnew_D timing, rfwe_D write enable;
//           stall_FD, bubble_E, fwd_Drs/fwd_Drt/fwd_Ers/fwd_Ert/fwd_Mrt selects.
//           With HAZARD_MDU_EN: md_start_D, md_div_D, md_use_D in, md_busy out.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  tnew_t      tuse_Drs;
  tnew_t      tuse_Drt;
  logic       rfwe_D;
  logic [4:0] wa_D;
  tnew_t      tnew_D;
  logic       stall_FD;
  logic       bubble_E;
  logic [1:0] fwd_Drs;
  logic [1:0] fwd_Drt;
  logic [1:0] fwd_Ers;
  logic [1:0] fwd_Ert;
  logic       fwd_Mrt;
`ifdef HAZARD_MDU_EN
  logic       md_start_D;
  logic       md_div_D;
  logic       md_use_D;
  logic       md_busy;
`endif

  // Decode/pipeline side.
  modport master (
    output rs_D, rt_D, tuse_Drs, tuse_Drt, rfwe_D, wa_D, tnew_D,
`ifdef HAZARD_MDU_EN
    output md_start_D, md_div_D, md_use_D,
    input  md_busy,
`endif
    input  stall_FD, bubble_E, fwd_Drs, fwd_Drt, fwd_Ers, fwd_Ert, fwd_Mrt
  );

  // Hazard controller side.
  modport slave (
    input  rs_D, rt_D, tuse_Drs, tuse_Drt, rfwe_D, wa_D, tnew_D,
`ifdef HAZARD_MDU_EN
    input  md_start_D, md_div_D, md_use_D,
    output md_busy,
`endif
    output stall_FD, bubble_E, fwd_Drs, fwd_Drt, fwd_Ers, fwd_Ert, fwd_Mrt
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// Purpose : one shadow pipeline stage (addresses, write enable, tnew) with bubble load.
// Latency : 1 cycle, tnew saturating-decremented (or cleared when CLR_TNEW) on the way in.
// Backpressure: none; bubble_i loads the all-zero bubble instead of d_i.
// Ports   : clk, reset (async active-high), d_i previous-stage value, bubble_i, q_o.
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
#(
  parameter bit CLR_TNEW = 1'b0
) (
  input  logic   clk,
  input  logic   reset,
  input  stage_t d_i,
  input  logic   bubble_i,
  output stage_t q_o
);

  stage_t q_q;
  stage_t q_d;

  always_comb begin
    q_d      = d_i;
    q_d.tnew = CLR_TNEW ? '0 : sat_dec(d_i.tnew);
    if (bubble_i) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose : stall and forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Latency : stall and all forwarding selects are combinational in the current cycle.
// Backpressure: stall_FD holds PC and F/D; bubble_E inserts a nop into D/E on the same cycle.
// Ports   : clk, reset (async active-high), bus (hazard_ctrl_if.slave).
// Option  : HAZARD_MDU_EN adds the multiply/divide busy tracker and its stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  stage_t d_stage;
  stage_t e_q;
  stage_t m_q;
  stage_t w_q;
  logic   stall;
  logic   data_stall;
  logic   md_stall;

  assign d_stage = '{rs:   bus.rs_D,
                     rt:   bus.rt_D,
                     wa:   bus.wa_D,
                     we:   bus.rfwe_D,
                     tnew: bus.tnew_D};

  // Shadow pipeline: E takes a bubble while D is stalled; M and W keep draining.
  hazard_stage_reg #(.CLR_TNEW(1'b0)) u_stage_e (
    .clk(clk), .reset(reset), .d_i(d_stage), .bubble_i(stall), .q_o(e_q)
  );
  hazard_stage_reg #(.CLR_TNEW(1'b0)) u_stage_m (
    .clk(clk), .reset(reset), .d_i(e_q), .bubble_i(1'b0), .q_o(m_q)
  );
  hazard_stage_reg #(.CLR_TNEW(1'b1)) u_stage_w (
    .clk(clk), .reset(reset), .d_i(m_q), .bubble_i(1'b0), .q_o(w_q)
  );

  // An operand must wait if a producer in s will not have its result by the
  // time D's instruction needs it. W is always ready, so it is never checked.
  function automatic logic op_hazard(logic [4:0] a, tnew_t tuse, stage_t s);
    return (a != 5'd0) && (tuse != TUSE_NONE) && wr_valid(s) &&
           (s.wa == a) && (s.tnew > tuse);
  endfunction

  // Youngest ready producer wins; later assignments override older stages.
  function automatic logic [1:0] sel_d(logic [4:0] a, stage_t e, stage_t m, stage_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (a != 5'd0) begin
      if (wr_valid(w) && (w.wa == a) && (w.tnew == '0)) sel = FWD_W;
      if (wr_valid(m) && (m.wa == a) && (m.tnew == '0)) sel = FWD_M;
      if (wr_valid(e) && (e.wa == a) && (e.tnew == '0)) sel = FWD_E;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(logic [4:0] a, stage_t m, stage_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_valid(w) && (w.wa == a)) sel = FWD_W;
    if (wr_valid(m) && (m.wa == a) && (m.tnew == '0)) sel = FWD_M;
    return sel;
  endfunction

  assign data_stall = op_hazard(bus.rs_D, bus.tuse_Drs, e_q) |
                      op_hazard(bus.rs_D, bus.tuse_Drs, m_q) |
                      op_hazard(bus.rt_D, bus.tuse_Drt, e_q) |
                      op_hazard(bus.rt_D, bus.tuse_Drt, m_q);

  // Gating with reset makes the outputs drop the instant reset rises, not
  // one delta after the shadow registers clear.
  assign stall = !reset && (data_stall || md_stall);

  assign bus.stall_FD = stall;
  assign bus.bubble_E = stall;
  assign bus.fwd_Drs  = (reset || stall) ? FWD_RF : sel_d(bus.rs_D, e_q, m_q, w_q);
  assign bus.fwd_Drt  = (reset || stall) ? FWD_RF : sel_d(bus.rt_D, e_q, m_q, w_q);
  assign bus.fwd_Ers  = reset ? FWD_RF : sel_e(e_q.rs, m_q, w_q);
  assign bus.fwd_Ert  = reset ? FWD_RF : sel_e(e_q.rt, m_q, w_q);
  assign bus.fwd_Mrt  = !reset && wr_valid(w_q) && (w_q.wa == m_q.rt) && (m_q.rt != 5'd0);

`ifdef HAZARD_MDU_EN
  localparam int MD_CNT_W = $clog2(MD_DIV_CYC + 1);

  logic [MD_CNT_W-1:0] md_cnt_q;
  logic [MD_CNT_W-1:0] md_cnt_d;
  logic                md_e_q;
  logic                md_e_d;
  logic                md_enter;
  logic                md_busy_int;

  // md_busy depends only on registered state, so the md stall cannot loop
  // back through md_enter.
  assign md_busy_int = (md_cnt_q != '0) || md_e_q;
  assign md_stall    = bus.md_use_D && md_busy_int;
  assign md_enter    = bus.md_start_D && !stall;
  assign bus.md_busy = !reset && md_busy_int;

  always_comb begin
    md_e_d   = md_enter;
    md_cnt_d = md_cnt_q;
    if (md_enter) begin
      md_cnt_d = bus.md_div_D ? MD_CNT_W'(MD_DIV_CYC) : MD_CNT_W'(MD_MULT_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q <= '0;
      md_e_q   <= 1'b0;
    end else begin
      md_cnt_q <= md_cnt_d;
      md_e_q   <= md_e_d;
    end
  end
`else
  assign md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose : directed self-checking bench for hazard_ctrl (stall, D/E/M forwarding, reset).
// Latency : inputs driven on the falling edge, outputs checked 1 ns later.
// Backpressure: the instruction held in D is re-driven while stall_FD is high.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  hazard_ctrl_if bus ();

  hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [2:0] ur, input logic [2:0] ut,
                       input logic we, input logic [4:0] wa, input logic [2:0] tn);
    bus.rs_D     = rs;
    bus.rt_D     = rt;
    bus.tuse_Drs = ur;
    bus.tuse_Drt = ut;
    bus.rfwe_D   = we;
    bus.wa_D     = wa;
    bus.tnew_D   = tn;
`ifdef HAZARD_MDU_EN
    bus.md_start_D = 1'b0;
    bus.md_div_D   = 1'b0;
    bus.md_use_D   = 1'b0;
`endif
  endtask

  task automatic set_nop();
    set_d(5'd0, 5'd0, 3'd5, 3'd5, 1'b0, 5'd0, 3'd0);
  endtask

  // Three nop cycles empty the E/M/W shadow stages.
  task automatic flush();
    set_nop();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_d(5'd1, 5'd1, 3'd1, 3'd1, 1'b1, 5'd2, 3'd2);
    @(negedge clk); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL rst_stall: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.bubble_E !== 1'b0) begin nerr++; $display("FAIL rst_bubble: got %b want 0", bus.bubble_E); end
    nvec++; if ({bus.fwd_Drs, bus.fwd_Drt, bus.fwd_Ers, bus.fwd_Ert, bus.fwd_Mrt} !== 9'd0)
      begin nerr++; $display("FAIL rst_fwd: got %h want 0", {bus.fwd_Drs, bus.fwd_Drt, bus.fwd_Ers, bus.fwd_Ert, bus.fwd_Mrt}); end
    reset = 1'b0;
    flush();
  endtask

  // lw $1 then addu $2,$1,$1: one stall, then W forwarding into E.
  task automatic test_load_use();
    @(negedge clk); set_d(5'd5, 5'd1, 3'd1, 3'd5, 1'b1, 5'd1, 3'd3); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL lu_lw_stall: got %b want 0", bus.stall_FD); end
    @(negedge clk); set_d(5'd1, 5'd1, 3'd1, 3'd1, 1'b1, 5'd2, 3'd2); #1;
    nvec++; if (bus.stall_FD !== 1'b1) begin nerr++; $display("FAIL lu_stall: got %b want 1", bus.stall_FD); end
    nvec++; if (bus.bubble_E !== 1'b1) begin nerr++; $display("FAIL lu_bubble: got %b want 1", bus.bubble_E); end
    @(negedge clk); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL lu_release: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drs !== FWD_RF) begin nerr++; $display("FAIL lu_fwd_Drs: got %0d want 0", bus.fwd_Drs); end
    nvec++; if (bus.fwd_Drt !== FWD_RF) begin nerr++; $display("FAIL lu_fwd_Drt: got %0d want 0", bus.fwd_Drt); end
    @(negedge clk); set_nop(); #1;
    nvec++; if (bus.fwd_Ers !== FWD_W) begin nerr++; $display("FAIL lu_fwd_Ers: got %0d want 3", bus.fwd_Ers); end
    nvec++; if (bus.fwd_Ert !== FWD_W) begin nerr++; $display("FAIL lu_fwd_Ert: got %0d want 3", bus.fwd_Ert); end
    flush();
  endtask

  // addu $3 then beq $3,$0: one stall, then forward from M.
  task automatic test_alu_branch();
    @(negedge clk); set_d(5'd6, 5'd7, 3'd1, 3'd1, 1'b1, 5'd3, 3'd2); #1;
    @(negedge clk); set_d(5'd3, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0); #1;
    nvec++; if (bus.stall_FD !== 1'b1) begin nerr++; $display("FAIL ab_stall: got %b want 1", bus.stall_FD); end
    @(negedge clk); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL ab_release: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drs !== FWD_M) begin nerr++; $display("FAIL ab_fwd_Drs: got %0d want 2", bus.fwd_Drs); end
    nvec++; if (bus.fwd_Drt !== FWD_RF) begin nerr++; $display("FAIL ab_fwd_Drt: got %0d want 0", bus.fwd_Drt); end
    flush();
  endtask

  // jal then jr $31: result ready in E, no stall.
  task automatic test_jal_jr();
    @(negedge clk); set_d(5'd0, 5'd0, 3'd5, 3'd5, 1'b1, 5'd31, 3'd0); #1;
    @(negedge clk); set_d(5'd31, 5'd0, 3'd0, 3'd5, 1'b0, 5'd0, 3'd0); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL jj_stall: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drs !== FWD_E) begin nerr++; $display("FAIL jj_fwd_Drs: got %0d want 1", bus.fwd_Drs); end
    flush();
  endtask

  // Writes to $0 never create hazards or forwards.
  task automatic test_zero_reg();
    @(negedge clk); set_d(5'd8, 5'd0, 3'd1, 3'd5, 1'b1, 5'd0, 3'd2); #1;
    @(negedge clk); set_d(5'd0, 5'd0, 3'd1, 3'd1, 1'b1, 5'd9, 3'd2); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL z_stall: got %b want 0", bus.stall_FD); end
    nvec++; if ({bus.fwd_Drs, bus.fwd_Drt} !== 4'd0) begin nerr++; $display("FAIL z_fwd_D: got %h want 0", {bus.fwd_Drs, bus.fwd_Drt}); end
    @(negedge clk); set_nop(); #1;
    nvec++; if ({bus.fwd_Ers, bus.fwd_Ert} !== 4'd0) begin nerr++; $display("FAIL z_fwd_E: got %h want 0", {bus.fwd_Ers, bus.fwd_Ert}); end
    flush();
  endtask

  // lw $4 then sw $4: store data needed late, so no stall; W->M forward.
  task automatic test_load_store();
    @(negedge clk); set_d(5'd10, 5'd4, 3'd1, 3'd5, 1'b1, 5'd4, 3'd3); #1;
    @(negedge clk); set_d(5'd11, 5'd4, 3'd1, 3'd2, 1'b0, 5'd0, 3'd0); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL ls_stall: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drt !== FWD_RF) begin nerr++; $display("FAIL ls_fwd_Drt: got %0d want 0", bus.fwd_Drt); end
    @(negedge clk); set_nop(); #1;
    nvec++; if (bus.fwd_Ert !== FWD_RF) begin nerr++; $display("FAIL ls_fwd_Ert: got %0d want 0", bus.fwd_Ert); end
    nvec++; if (bus.fwd_Mrt !== 1'b0) begin nerr++; $display("FAIL ls_fwd_Mrt_early: got %b want 0", bus.fwd_Mrt); end
    @(negedge clk); #1;
    nvec++; if (bus.fwd_Mrt !== 1'b1) begin nerr++; $display("FAIL ls_fwd_Mrt: got %b want 1", bus.fwd_Mrt); end
    flush();
  endtask

  // lw $1 then beq $1: two stall cycles while tnew decays, then W forward.
  task automatic test_multi_stall();
    @(negedge clk); set_d(5'd5, 5'd1, 3'd1, 3'd5, 1'b1, 5'd1, 3'd3); #1;
    @(negedge clk); set_d(5'd1, 5'd0, 3'd0, 3'd0, 1'b0, 5'd0, 3'd0); #1;
    nvec++; if (bus.stall_FD !== 1'b1) begin nerr++; $display("FAIL ms_stall1: got %b want 1", bus.stall_FD); end
    @(negedge clk); #1;
    nvec++; if (bus.stall_FD !== 1'b1) begin nerr++; $display("FAIL ms_stall2: got %b want 1", bus.stall_FD); end
    @(negedge clk); #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL ms_release: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drs !== FWD_W) begin nerr++; $display("FAIL ms_fwd_Drs: got %0d want 3", bus.fwd_Drs); end
    flush();
  endtask

  // Reset during a load-use stall clears it at once and empties the pipeline.
  task automatic test_reset_mid_stall();
    @(negedge clk); set_d(5'd5, 5'd1, 3'd1, 3'd5, 1'b1, 5'd1, 3'd3); #1;
    @(negedge clk); set_d(5'd1, 5'd1, 3'd1, 3'd1, 1'b1, 5'd2, 3'd2); #1;
    nvec++; if (bus.stall_FD !== 1'b1) begin nerr++; $display("FAIL rm_stall: got %b want 1", bus.stall_FD); end
    reset = 1'b1; #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL rm_async_stall: got %b want 0", bus.stall_FD); end
    nvec++; if ({bus.fwd_Drs, bus.fwd_Drt, bus.fwd_Ers, bus.fwd_Ert, bus.fwd_Mrt} !== 9'd0)
      begin nerr++; $display("FAIL rm_async_fwd: got %h want 0", {bus.fwd_Drs, bus.fwd_Drt, bus.fwd_Ers, bus.fwd_Ert, bus.fwd_Mrt}); end
    @(negedge clk); reset = 1'b0; #1;
    nvec++; if (bus.stall_FD !== 1'b0) begin nerr++; $display("FAIL rm_after_stall: got %b want 0", bus.stall_FD); end
    nvec++; if (bus.fwd_Drs !== FWD_RF) begin nerr++; $display("FAIL rm_after_fwd: got %0d want 0", bus.fwd_Drs); end
    flush();
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    set_nop();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_jal_jr();
    test_zero_reg();
    test_load_store();
    test_multi_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the D-stage decode outputs: register addresses, tuse_Drs/tuse_Drt, rfwe_D, tnew_D.
- Keeps its own shadow pipeline of destination/tnew per stage and produces the F/D stall, the E bubble insert, and the forwarding mux selects for the D, E and M stages.
- Sits beside the D/E/M/W pipeline registers and drives their enables and flushes.

Parameters:
TNEW_W, 3, width of tuse/tnew fields
MD_MULT_CYC, 5, busy cycles for mult/multu (feature only)
MD_DIV_CYC, 10, busy cycles for div/divu (feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rs_D  in  5  D-stage rs address
rt_D  in  5  D-stage rt address
tuse_Drs  in  3  cycles until rs needed (5 = unused)
tuse_Drt  in  3  cycles until rt needed (5 = unused)
rfwe_D  in  1  D instr writes regfile
wa_D  in  5  D-stage resolved write address (rt/rd/31)
tnew_D  in  3  cycles until result ready, counted from D
stall_FD  out  1  hold PC and the F/D register
bubble_E  out  1  load a nop into the D/E register
fwd_Drs  out  2  0 = RF, 1 = E, 2 = M, 3 = W
fwd_Drt  out  2  same encoding
fwd_Ers  out  2  0 = pipe reg, 2 = M, 3 = W
fwd_Ert  out  2  same encoding
fwd_Mrt  out  1  0 = pipe reg, 1 = W

Behaviour:
- Shadow registers per stage S in {E, M, W}: rs_S, rt_S, wa_S, we_S, tnew_S. All update at posedge clk.
- Reset (async, immediate): all shadow registers cleared to 0, which is the bubble state.
- Shadow advance each cycle:
  - E <= D-stage values, with tnew_E = sat(tnew_D - 1).
  - On a stall, E instead <= bubble (all zero).
  - M <= E, with tnew_M = sat(tnew_E - 1).
  - W <= M, with tnew_W = 0.
  - sat() floors at 0.
- Write-valid for stage S: wv_S = we_S && wa_S != 0.
- Stall condition (combinational, same cycle). For each operand X in {rs, rt} with addr_X != 0, stall if either holds:
  - wv_E && wa_E == addr_X && tnew_E > tuse_DX
  - wv_M && wa_M == addr_X && tnew_M > tuse_DX
  - W never causes a stall.
- Stall outputs: stall_FD = bubble_E = stall. Both are 0 during reset.
- D forwarding: when not stalling, pick the youngest stage S in E, then M, then W where wv_S, wa_S == addr, and tnew_S == 0.
  - E, M, W give codes 1, 2, 3; if none match, 0.
  - Address 0 always gives 0.
- E forwarding: over rs_E/rt_E, pick M (code 2) if wv_M, match and tnew_M == 0; else W (code 3) if wv_W and match; else 0.
- M forwarding: fwd_Mrt = wv_W && wa_W == rt_M && rt_M != 0.
- All forwarding selects read 0 during reset and for bubbles.
- tuse of 5 means the operand is unused. It never stalls, and its select value is don't-care but must be driven (0 when no match).
- Reset mid-stall: the stall clears immediately and the shadow pipeline empties.
- Stall persisting several cycles: E receives a bubble each cycle and M/W keep draining, so tnew decays until the hazard resolves.

Optional Feature:
- Macro: HAZARD_MDU_EN.
- Ports added: md_start_D (in, 1, D instr is mult/multu/div/divu), md_div_D (in, 1, the op is a divide), md_use_D (in, 1, D instr is mfhi/mflo/mthi/mtlo/md-start), md_busy (out, 1).
- Busy counter loaded when an md op enters E (not stalled): MD_MULT_CYC or MD_DIV_CYC. It decrements each cycle to 0.
- md_busy = counter != 0 || md op currently in E.
- Extra stall when md_use_D && md_busy.
- Counter cleared by reset.
- Without the macro: these ports and logic are absent, and behaviour is exactly as above.

Decomposition:
- Shared package holds:
  - fwd encodings: FWD_RF = 0, FWD_E = 1, FWD_M = 2, FWD_W = 3
  - TUSE_NONE = 5
  - TNEW_W
  - the md cycle constants, which are also used by the decoder and the bypass muxes
- One sub-module, hazard_stage_reg: a shadow stage register with tnew saturating decrement and bubble load, instantiated for E, M and W.

Test Plan:
- lw $1 (tnew_D = 3), then addu $2,$1,$1 (tuse 1/1): exactly one stall cycle (tnew_E = 2 > 1). Next cycle no stall and fwd_Drs = 0. Following cycle addu is in E, lw in W, fwd_Ers = fwd_Ert = 3.
- addu $3 (tnew_D = 2), then beq $3,$0 (tuse 0): one stall (tnew_E = 1). Next cycle fwd_Drs = 2 from M and fwd_Drt = 0.
- jal (tnew_D = 0, wa 31), then jr $31 (tuse 0): no stall, fwd_Drs = 1.
- ori with wa = 0, then addu reading $0: no stall, all selects 0.
- lw $4, then sw $4 (tuse_Drt = 2): no stall. At M, fwd_Mrt = 1 when lw is in W.
- Assert reset during a lw→use stall: stall_FD drops asynchronously and all selects are 0. After release, the same dependent instruction issues with no stall.
